// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the front half of the MIPS pipeline:
//                control-bundle field positions, forward-select encodings
//                and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Bit positions inside the 8-bit decoded control bundle
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUC_HI  = 4;
    localparam int CTRL_ALUC_LO  = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGDST   = 0;

    // Execute-stage operand forward selects; 2'b11 falls back to register file
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/front_pipe_flopenrc.sv
`default_nettype none
// ============================================================================
//  Module      : flopenrc
//  Description : Register with asynchronous reset, load enable and a
//                synchronous clear that only takes effect when enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module flopenrc #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Hold while disabled; clear loses to a held register (enable gates clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= RESET_VAL;
        end else if (i_en) begin
            o_q <= i_clr ? '0 : i_d;
        end
    end

endmodule : flopenrc
`default_nettype wire

// File: rtl/front_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : front_pipe
//  Description : Fetch/Decode/Execute front end of a five-stage MIPS pipe:
//                PC, IF/ID and ID/EX registers, branch-compare forwarding in
//                Decode and ALU-operand forwarding in Execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module front_pipe
    import pipe_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             pcsrcD,
    input  logic             forwardAD,
    input  logic             forwardBD,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [WIDTH-1:0] pcnextF,
    input  logic [31:0]      instrF,
    input  logic [7:0]       ctrlD,
    input  logic [WIDTH-1:0] rd1D,
    input  logic [WIDTH-1:0] rd2D,
    input  logic [WIDTH-1:0] signimmD,
    input  logic [WIDTH-1:0] aluoutM,
    input  logic [WIDTH-1:0] resultW,
    output logic [WIDTH-1:0] pcF,
    output logic [31:0]      instrD,
    output logic [WIDTH-1:0] pcplus4D,
    output logic             equalD,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       writeregE,
    output logic [7:0]       ctrlE,
    output logic [WIDTH-1:0] srcAE,
    output logic [WIDTH-1:0] srcBE,
    output logic [WIDTH-1:0] writedataE
);

    localparam int c_IDEX_W = 8 + 3 * WIDTH + 15;

    logic [WIDTH-1:0]    w_pcplus4F;
    logic [WIDTH-1:0]    w_cmpA;
    logic [WIDTH-1:0]    w_cmpB;
    logic [c_IDEX_W-1:0] w_idexD;
    logic [c_IDEX_W-1:0] r_idexQ;
    logic [WIDTH-1:0]    r_rd1E;
    logic [WIDTH-1:0]    r_rd2E;
    logic [WIDTH-1:0]    r_signimmE;
    logic [4:0]          r_rdE;

    // Wraps modulo 2^WIDTH by construction
    assign w_pcplus4F = pcF + WIDTH'(4);

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pcReg (
        .clk   (clk),
        .rst   (reset),
        .i_en  (~stallF),
        .i_clr (1'b0),
        .i_d   (pcnextF),
        .o_q   (pcF)
    );

    // A taken branch squashes the fetched instruction, unless Decode is held
    flopenrc #(.WIDTH(32 + WIDTH), .RESET_VAL('0)) u_ifidReg (
        .clk   (clk),
        .rst   (reset),
        .i_en  (~stallD),
        .i_clr (pcsrcD),
        .i_d   ({instrF, w_pcplus4F}),
        .o_q   ({instrD, pcplus4D})
    );

    assign w_idexD = {ctrlD, rd1D, rd2D, instrD[25:21], instrD[20:16],
                      instrD[15:11], signimmD};

    // Always loads; a flush writes an all-zero bubble (regwrite/memwrite off)
    flopenrc #(.WIDTH(c_IDEX_W), .RESET_VAL('0)) u_idexReg (
        .clk   (clk),
        .rst   (reset),
        .i_en  (1'b1),
        .i_clr (flushE),
        .i_d   (w_idexD),
        .o_q   (r_idexQ)
    );

    assign {ctrlE, r_rd1E, r_rd2E, rsE, rtE, r_rdE, r_signimmE} = r_idexQ;

    // Destination register is purely registered state, keeping the hazard loop acyclic
    assign writeregE = ctrlE[CTRL_REGDST] ? r_rdE : rtE;

    // Branch comparison with Memory-stage forwarding
    always_comb begin
        w_cmpA = forwardAD ? aluoutM : rd1D;
        w_cmpB = forwardBD ? aluoutM : rd2D;
        equalD = (w_cmpA == w_cmpB);
    end

    // Execute operand A forwarding; unused encoding selects the register file
    always_comb begin
        srcAE = r_rd1E;
        case (forwardAE)
            FWD_W:   srcAE = resultW;
            FWD_M:   srcAE = aluoutM;
            default: srcAE = r_rd1E;
        endcase
    end

    // Execute operand B / store data forwarding, then immediate select
    always_comb begin
        writedataE = r_rd2E;
        case (forwardBE)
            FWD_W:   writedataE = resultW;
            FWD_M:   writedataE = aluoutM;
            default: writedataE = r_rd2E;
        endcase
        srcBE = ctrlE[CTRL_ALUSRC] ? r_signimmE : writedataE;
    end

endmodule : front_pipe
`default_nettype wire
